// File: rtl/modulate_quarter_rot_mc.sv
// modulate_quarter_rot_mc
// Multi-channel complex rotator: each accepted sample is multiplied by j^q,
// where q is a 2-bit per-channel phase that advances by 'step' on every
// accepted sample of that channel. One-stage registered output with
// valid/ready handshake, one sample per clock.
// Optional feature macro: MODULATE_SAT_EN (saturating negation of the most
// negative value, flagged on dout_sat). Undefined: negation wraps.
module modulate_quarter_rot_mc #(
   parameter int  G_DWIDTH = 24,
   parameter int  G_NCH    = 2,
   localparam int CW       = (G_NCH > 1) ? $clog2(G_NCH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          step,
   input  logic                phase_clr,
   input  logic [G_DWIDTH-1:0] din_re,
   input  logic [G_DWIDTH-1:0] din_im,
   input  logic [CW-1:0]       din_chan,
   input  logic                din_valid,
   output logic                din_ready,
   output logic [G_DWIDTH-1:0] dout_re,
   output logic [G_DWIDTH-1:0] dout_im,
   output logic [CW-1:0]       dout_chan,
   output logic                dout_sat,
   output logic                dout_valid,
   input  logic                dout_ready
);

   typedef enum logic {SM_INIT, SM_RUN} state_t;

   state_t              state_reg, state_next;
   logic [1:0]          phase_reg [G_NCH];
   logic [G_NCH-1:0]    chan_hit;
   logic                chan_ok;
   logic [1:0]          q_sel;
   logic                accept;
   logic [G_DWIDTH-1:0] rot_re, rot_im;
   logic                rot_sat;
   logic [G_DWIDTH:0]   neg_re, neg_im;
   logic [G_DWIDTH-1:0] dout_re_reg, dout_im_reg;
   logic [CW-1:0]       dout_chan_reg;
   logic                dout_sat_reg, dout_valid_reg;

   // Two's complement negation; returns {saturated, value}.
   function automatic logic [G_DWIDTH:0] negate(input logic [G_DWIDTH-1:0] x);
      logic [G_DWIDTH-1:0] r;
      logic                s;
      r = -x;
      s = 1'b0;
`ifdef MODULATE_SAT_EN
      if (x == {1'b1, {(G_DWIDTH-1){1'b0}}}) begin
         r = {1'b0, {(G_DWIDTH-1){1'b1}}};
         s = 1'b1;
      end
`endif
      return {s, r};
   endfunction

   // Per-channel decode of the incoming channel index; out-of-range indices hit nothing.
   for (genvar gi = 0; gi < G_NCH; gi++) begin : g_hit
      assign chan_hit[gi] = (din_chan == CW'(gi));
   end

   assign chan_ok = |chan_hit;
   assign accept  = din_valid && din_ready;

   // State register.
   always_ff @(posedge clk) begin
      state_reg <= state_next;
   end

   // Next state and input ready; reset or enable low forces SM_INIT.
   always_comb begin
      state_next = state_reg;
      din_ready  = 1'b0;
      if (reset || !enable) begin
         state_next = SM_INIT;
      end else begin
         case (state_reg)
            SM_INIT: state_next = SM_RUN;
            SM_RUN:  state_next = SM_RUN;
            default: state_next = SM_INIT;
         endcase
      end
      din_ready = (state_reg == SM_RUN) && (!dout_valid_reg || dout_ready);
   end

   // Phase selection for the incoming sample; phase_clr or an unknown channel forces q=0.
   always_comb begin
      q_sel = 2'd0;
      for (int i = 0; i < G_NCH; i++) begin
         if (chan_hit[i]) q_sel = phase_reg[i];
      end
      if (phase_clr) q_sel = 2'd0;
   end

   // Quarter-turn rotation by j^q_sel.
   always_comb begin
      neg_re  = negate(din_re);
      neg_im  = negate(din_im);
      rot_re  = din_re;
      rot_im  = din_im;
      rot_sat = 1'b0;
      case (q_sel)
         2'd1: begin
            rot_re  = neg_im[G_DWIDTH-1:0];
            rot_im  = din_re;
            rot_sat = neg_im[G_DWIDTH];
         end
         2'd2: begin
            rot_re  = neg_re[G_DWIDTH-1:0];
            rot_im  = neg_im[G_DWIDTH-1:0];
            rot_sat = neg_re[G_DWIDTH] | neg_im[G_DWIDTH];
         end
         2'd3: begin
            rot_re  = din_im;
            rot_im  = neg_re[G_DWIDTH-1:0];
            rot_sat = neg_re[G_DWIDTH];
         end
         default: ;
      endcase
   end

   // Phase accumulators: advance the accepted channel, clear all on phase_clr.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         for (int i = 0; i < G_NCH; i++) phase_reg[i] <= 2'd0;
      end else begin
         for (int i = 0; i < G_NCH; i++) begin
            if (accept && chan_ok && chan_hit[i])
               phase_reg[i] <= q_sel + step;
            else if (phase_clr)
               phase_reg[i] <= 2'd0;
         end
      end
   end

   // Output stage: load on accept, drop valid once consumed, hold while stalled.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         dout_re_reg    <= '0;
         dout_im_reg    <= '0;
         dout_chan_reg  <= '0;
         dout_sat_reg   <= 1'b0;
         dout_valid_reg <= 1'b0;
      end else if (accept) begin
         dout_re_reg    <= rot_re;
         dout_im_reg    <= rot_im;
         dout_chan_reg  <= din_chan;
         dout_sat_reg   <= rot_sat;
         dout_valid_reg <= 1'b1;
      end else if (dout_valid_reg && dout_ready) begin
         dout_valid_reg <= 1'b0;
      end
   end

   assign dout_re    = dout_re_reg;
   assign dout_im    = dout_im_reg;
   assign dout_chan  = dout_chan_reg;
   assign dout_sat   = dout_sat_reg;
   assign dout_valid = dout_valid_reg;

endmodule

// File: doc/modulate_quarter_rot_mc.md
# modulate_quarter_rot_mc

Multi-channel complex rotator that multiplies each input sample by j^q, with q being a 2-bit per-channel phase advanced by a programmable step on every accepted sample. It performs fs/4-family frequency shifts (step 1 = +fs/4, 2 = fs/2, 3 = −fs/4, 0 = bypass) on a time-multiplexed stream ahead of the vibrato delay/interpolation path. The datapath is fully pipelined, accepts one sample per clock, and supports optional saturating negation.

## Interface
- G_DWIDTH, 24: sample width of re/im, two's complement.
- G_NCH, 2: number of independent channels, ≥1; channel index width CW = max(1, $clog2(G_NCH)).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  low = synchronous clear identical to reset.
- step  in  2  phase increment applied to the channel of each accepted sample.
- phase_clr  in  1  single-cycle pulse; zeroes all channel phases.
- din_re, din_im  in  G_DWIDTH  input sample.
- din_chan  in  CW  channel of input sample.
- din_valid  in  1  input valid.
- din_ready  out  1  input ready.
- dout_re, dout_im  out  G_DWIDTH  rotated sample.
- dout_chan  out  CW  channel of output sample.
- dout_sat  out  1  saturation occurred on this sample.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.

## Operation
- States: SM_INIT, SM_RUN. Reset/!enable → SM_INIT; SM_INIT → SM_RUN unconditionally after 1 cycle.
- din_ready = (state==SM_RUN) && (!dout_valid || dout_ready).
- Accept = din_valid && din_ready. On accept with c = din_chan and q = phase[c] (or 0 if phase_clr is high the same cycle):
  - q=0: (re, im); q=1: (−im, re); q=2: (−re, −im); q=3: (im, −re).
  - Result, c, and dout_sat are registered into the output stage; dout_valid ← 1.
  - phase[c] ← q + step (mod 4).
- phase_clr without accept: all phases ← 0. With accept: all phases ← 0 except phase[c] ← step.
- Output stage: if dout_valid && dout_ready && !accept → dout_valid ← 0. dout_* hold stable while dout_valid && !dout_ready.
- din_chan ≥ G_NCH: sample passes with q=0, no phase update, dout_chan = din_chan.
- Negation is two's complement at G_DWIDTH. −(−2^(G_DWIDTH−1)) behaviour is set by the Configuration section.
- step is sampled only on accept; it may change every cycle.

## Timing
- Reset values: din_ready 0, dout_valid 0, dout_sat 0, dout_re/im/chan 0, all phases 0, state SM_INIT.
- First din_ready = 1 on the second cycle after reset deasserts.
- Latency: 1 cycle, accept → dout_valid.
- Throughput: 1 sample/clk while dout_ready stays high.
- Backpressure: dout_ready low with dout_valid high → din_ready low in the same cycle (combinational path dout_ready→din_ready).
- Reset or enable drop mid-stream: the in-flight output is discarded and the phases are lost.

## Configuration
- MODULATE_SAT_EN defined: the negation of −2^(G_DWIDTH−1) yields 2^(G_DWIDTH−1)−1, and dout_sat = 1 for that sample.
- MODULATE_SAT_EN undefined: the negation wraps (the result equals the input), and dout_sat is tied to 0.

## Test plan
- Channel 0, step=1, four samples of (100, 200) → (100, 200), (−200, 100), (−100, −200), (200, −100); the fifth sample gives (100, 200).
- G_NCH=2, alternating channels, ch0 step=1, ch1 step=3, input (5, 7) → ch0 sequence (5,7),(−7,5),…; ch1 sequence (5,7),(7,−5),…; the two phases advance independently.
- phase_clr asserted on the same cycle as the third accept on ch0 (step 1) → that output is (100, 200) unrotated, and the next ch0 output is (−200, 100).
- Random dout_ready toggling with continuous din_valid → no loss or duplication, order preserved, dout held stable while stalled, full rate whenever ready is high.
- Input (−8388608, 0), q=2 → with MODULATE_SAT_EN: (8388607, 0), dout_sat=1; without it: (−8388608, 0), dout_sat=0.
- Reset pulsed while dout_valid=1 and stalled → next cycle dout_valid=0 and din_ready=0; din_ready=1 one cycle after reset releases, and the phase restarts at 0.
